// File: rtl/npc_multicycle_ctrl_if.sv
// Handshake bundle between the NPC sequencer and its fetch / load-store units.
// Valid/ready rule for both request channels: the master raises *_req_valid
// (and lsu_we) and holds them unchanged until the cycle in which *_req_ready
// is also 1; that cycle is the transfer. *_rsp_valid is a one-cycle response
// strobe that the master only samples in its matching wait state.
interface npc_multicycle_ctrl_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_rsp_valid;
  logic lsu_req_valid;
  logic lsu_req_ready;
  logic lsu_rsp_valid;
  logic lsu_we;

  modport master (
    output ifu_req_valid, lsu_req_valid, lsu_we,
    input  ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid, lsu_req_valid, lsu_we,
    output ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/npc_multicycle_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch, execute, memory, writeback.
// Counts retired instructions and sends the core to ERR when a request or
// wait state lingers for more than TIMEOUT cycles.
module npc_multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic                  zero,
  npc_multicycle_ctrl_if.master bus,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic                  rf_we,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      retired,
  output logic                  trap,
  output logic                  err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_EX       = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  retired_q;

  logic ifu_v, lsu_v, lsu_we_c;
  logic ir_we_c, pc_we_c, pc_sel_c, rf_we_c;
  logic retire_inc;
  logic wait_st;   // state waits on an external handshake and is timed
  logic hs;        // exit handshake of the current wait state
  logic is_store;

  assign is_store = (op == 7'd35);

  // Next-state decode, Mealy strobes and timeout escape.
  always_comb begin
    state_d    = state_q;
    ifu_v      = 1'b0;
    lsu_v      = 1'b0;
    lsu_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    rf_we_c    = 1'b0;
    retire_inc = 1'b0;
    wait_st    = 1'b0;
    hs         = 1'b0;
    case (state_q)
      S_IF_REQ: begin
        ifu_v   = 1'b1;
        wait_st = 1'b1;
        hs      = bus.ifu_req_ready;
        if (hs) state_d = S_IF_WAIT;
      end
      S_IF_WAIT: begin
        wait_st = 1'b1;
        hs      = bus.ifu_rsp_valid;
        if (hs) begin
          ir_we_c = 1'b1;
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (op)
          7'd3, 7'd35: state_d = S_MEM_REQ;
          7'd51, 7'd19, 7'd23, 7'd111, 7'd103: state_d = S_WB;
          7'd99: begin
            // Branches resolve here and never visit WB.
            pc_we_c    = 1'b1;
            pc_sel_c   = zero;
            retire_inc = 1'b1;
            state_d    = S_IF_REQ;
          end
          7'd115:  state_d = S_HALT;
          default: state_d = S_ERR;
        endcase
      end
      S_MEM_REQ: begin
        lsu_v    = 1'b1;
        lsu_we_c = is_store;
        wait_st  = 1'b1;
        hs       = bus.lsu_req_ready;
        if (hs) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        wait_st = 1'b1;
        hs      = bus.lsu_rsp_valid;
        if (hs) begin
          if (is_store) begin
            pc_we_c    = 1'b1;
            retire_inc = 1'b1;
            state_d    = S_IF_REQ;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we_c    = 1'b1;
        pc_we_c    = 1'b1;
        pc_sel_c   = (op == 7'd111) || (op == 7'd103);
        retire_inc = 1'b1;
        state_d    = S_IF_REQ;
      end
      default: state_d = state_q;  // HALT and ERR hold until reset
    endcase

    // A handshake in the last allowed cycle still wins.
    if (wait_st && !hs && (tmo_q == TMO_MAX)) state_d = S_ERR;

    if (state_d != state_q) tmo_d = '0;
    else if (wait_st)       tmo_d = tmo_q + 1'b1;
    else                    tmo_d = tmo_q;
  end

  // State, timeout counter and retired counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF_REQ;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (retire_inc) retired_q <= retired_q + 1'b1;
    end
  end

  // Outputs are held low while reset is asserted so nothing leaks on the reset edge.
  assign bus.ifu_req_valid = ifu_v & ~rst;
  assign bus.lsu_req_valid = lsu_v & ~rst;
  assign bus.lsu_we        = lsu_we_c & ~rst;
  assign ir_we             = ir_we_c & ~rst;
  assign pc_we             = pc_we_c & ~rst;
  assign pc_sel            = pc_sel_c & ~rst;
  assign rf_we             = rf_we_c & ~rst;
  assign trap              = (state_q == S_HALT) & ~rst;
  assign err               = (state_q == S_ERR) & ~rst;
  assign state             = state_q;
  assign retired           = retired_q;

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
// Directed bench for npc_multicycle_ctrl, built with CNT_W=4 and TIMEOUT=4 so
// counter wrap and timeout are reachable in a few cycles.
module tb_npc_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       ir_we, pc_we, pc_sel, rf_we, trap, err;
  logic [2:0] state;
  logic [3:0] retired;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_retired;
  logic [2:0] exp_q[$];
  logic [2:0] exp_s;

  npc_multicycle_ctrl_if bus ();

  npc_multicycle_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .bus(bus),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .state(state), .retired(retired), .trap(trap), .err(err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    op = 7'd0;
    zero = 1'b0;
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    exp_retired = 4'd0;
  endtask

  // From an IF_REQ cycle, fetch one instruction with zero-latency IFU; returns in EX.
  task automatic fetch(input logic [6:0] opc);
    op = opc;
    bus.ifu_req_ready = 1'b1;
    step();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    step();
    bus.ifu_rsp_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if (bus.ifu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_ifu_valid_forced: got %b expected 0", bus.ifu_req_valid); end
    checks++; if ({trap, err} !== 2'b00) begin errors++; $display("FAIL reset_trap_err: got %b expected 00", {trap, err}); end
    rst = 1'b0;
    #1;
    exp_retired = 4'd0;
    checks++; if (bus.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL reset_release_ifu_valid: got %b expected 1", bus.ifu_req_valid); end
  endtask

  task automatic test_alu();
    exp_q = {3'd0, 3'd1, 3'd2, 3'd5, 3'd0};
    op = 7'd51;
    for (int c = 1; c <= 5; c++) begin
      bus.ifu_req_ready = (c == 1);
      bus.ifu_rsp_valid = (c == 2);
      #1;
      exp_s = exp_q.pop_front();
      checks++; if (state !== exp_s) begin errors++; $display("FAIL alu_state_c%0d: got %0d expected %0d", c, state, exp_s); end
      if (c == 2) begin
        checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL alu_ir_we: got %b expected 1", ir_we); end
      end
      if (c == 4) begin
        checks++; if ({rf_we, pc_we, pc_sel} !== 3'b110) begin errors++; $display("FAIL alu_wb_strobes: got %b expected 110", {rf_we, pc_we, pc_sel}); end
      end
      if (c < 5) step();
    end
    exp_retired = exp_retired + 4'd1;
    checks++; if (retired !== exp_retired) begin errors++; $display("FAIL alu_retired: got %0d expected %0d", retired, exp_retired); end
  endtask

  task automatic test_load_delayed();
    fetch(7'd3);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL load_ex: got %0d expected 2", state); end
    step();
    for (int i = 0; i < 4; i++) begin
      bus.lsu_req_ready = (i == 3);
      #1;
      checks++; if ({state, bus.lsu_req_valid, bus.lsu_we} !== {3'd3, 1'b1, 1'b0}) begin
        errors++; $display("FAIL load_req_hold_%0d: got state=%0d valid=%b we=%b expected state=3 valid=1 we=0", i, state, bus.lsu_req_valid, bus.lsu_we);
      end
      step();
    end
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    #1;
    checks++; if ({state, rf_we} !== {3'd4, 1'b0}) begin errors++; $display("FAIL load_mem_wait: got state=%0d rf_we=%b expected state=4 rf_we=0", state, rf_we); end
    step();
    bus.lsu_rsp_valid = 1'b0;
    #1;
    checks++; if ({state, rf_we, pc_we, pc_sel} !== {3'd5, 3'b110}) begin errors++; $display("FAIL load_wb: got state=%0d strobes=%b expected state=5 strobes=110", state, {rf_we, pc_we, pc_sel}); end
    step();
    exp_retired = exp_retired + 4'd1;
    checks++; if ({state, retired} !== {3'd0, exp_retired}) begin errors++; $display("FAIL load_retire: got state=%0d retired=%0d expected state=0 retired=%0d", state, retired, exp_retired); end
  endtask

  task automatic test_store();
    fetch(7'd35);
    bus.lsu_req_ready = 1'b1;
    step();
    #1;
    checks++; if ({state, bus.lsu_req_valid, bus.lsu_we} !== {3'd3, 2'b11}) begin errors++; $display("FAIL store_req: got state=%0d valid=%b we=%b expected state=3 valid=1 we=1", state, bus.lsu_req_valid, bus.lsu_we); end
    step();
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    #1;
    checks++; if ({pc_we, pc_sel, rf_we} !== 3'b100) begin errors++; $display("FAIL store_done: got %b expected 100", {pc_we, pc_sel, rf_we}); end
    step();
    bus.lsu_rsp_valid = 1'b0;
    exp_retired = exp_retired + 4'd1;
    #1;
    checks++; if ({state, retired} !== {3'd0, exp_retired}) begin errors++; $display("FAIL store_retire: got state=%0d retired=%0d expected state=0 retired=%0d", state, retired, exp_retired); end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      fetch(7'd99);
      checks++; if ({state, pc_we, pc_sel, rf_we} !== {3'd2, 1'b1, z[0], 1'b0}) begin
        errors++; $display("FAIL branch_z%0d: got state=%0d pc_we=%b pc_sel=%b rf_we=%b expected state=2 pc_we=1 pc_sel=%0d rf_we=0", z, state, pc_we, pc_sel, rf_we, z);
      end
      step();
      exp_retired = exp_retired + 4'd1;
      checks++; if ({state, retired} !== {3'd0, exp_retired}) begin errors++; $display("FAIL branch_retire_z%0d: got state=%0d retired=%0d expected state=0 retired=%0d", z, state, retired, exp_retired); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    fetch(7'd111);
    step();
    #1;
    checks++; if ({state, rf_we, pc_we, pc_sel} !== {3'd5, 3'b111}) begin errors++; $display("FAIL jump_wb: got state=%0d strobes=%b expected state=5 strobes=111", state, {rf_we, pc_we, pc_sel}); end
    step();
    exp_retired = exp_retired + 4'd1;
  endtask

  task automatic test_ignore_rsp();
    bus.ifu_rsp_valid = 1'b1;
    bus.lsu_rsp_valid = 1'b1;
    #1;
    checks++; if (ir_we !== 1'b0) begin errors++; $display("FAIL ignore_rsp_ir_we: got %b expected 0", ir_we); end
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ignore_rsp_state: got %0d expected 0", state); end
    bus.ifu_rsp_valid = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    #1;
  endtask

  task automatic test_halt();
    fetch(7'd115);
    step();
    bus.ifu_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({state, trap, bus.ifu_req_valid} !== {3'd6, 1'b1, 1'b0}) begin
        errors++; $display("FAIL halt_hold_%0d: got state=%0d trap=%b ifu_valid=%b expected state=6 trap=1 ifu_valid=0", i, state, trap, bus.ifu_req_valid);
      end
      step();
    end
    checks++; if (retired !== exp_retired) begin errors++; $display("FAIL halt_retired: got %0d expected %0d", retired, exp_retired); end
    reset_dut();
    checks++; if ({state, trap} !== {3'd0, 1'b0}) begin errors++; $display("FAIL halt_reset: got state=%0d trap=%b expected state=0 trap=0", state, trap); end
  endtask

  task automatic test_illegal();
    fetch(7'd0);
    step();
    checks++; if ({state, err} !== {3'd7, 1'b1}) begin errors++; $display("FAIL illegal_op: got state=%0d err=%b expected state=7 err=1", state, err); end
    reset_dut();
  endtask

  task automatic test_timeout();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL timeout_wait_%0d: got %0d expected 0", i, state); end
      step();
    end
    checks++; if ({state, err, bus.ifu_req_valid} !== {3'd7, 2'b10}) begin errors++; $display("FAIL timeout_err: got state=%0d err=%b ifu_valid=%b expected state=7 err=1 ifu_valid=0", state, err, bus.ifu_req_valid); end
    reset_dut();
    for (int i = 0; i < 4; i++) step();
    bus.ifu_req_ready = 1'b1;
    step();
    bus.ifu_req_ready = 1'b0;
    #1;
    checks++; if ({state, err} !== {3'd1, 1'b0}) begin errors++; $display("FAIL timeout_last_cycle_hs: got state=%0d err=%b expected state=1 err=0", state, err); end
    reset_dut();
  endtask

  task automatic test_back_to_back_wrap();
    reset_dut();
    for (int n = 0; n < 17; n++) begin
      fetch(7'd19);
      step();
      step();
    end
    checks++; if (retired !== 4'd1) begin errors++; $display("FAIL wrap_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_reset_mid();
    fetch(7'd3);
    bus.lsu_req_ready = 1'b1;
    step();
    step();
    bus.lsu_req_ready = 1'b0;
    #1;
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL mid_reach_wait: got %0d expected 4", state); end
    rst = 1'b1;
    bus.lsu_rsp_valid = 1'b1;
    #1;
    checks++; if ({bus.lsu_req_valid, pc_we, rf_we} !== 3'b000) begin errors++; $display("FAIL mid_reset_strobes: got %b expected 000", {bus.lsu_req_valid, pc_we, rf_we}); end
    step();
    rst = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    #1;
    checks++; if ({state, retired, bus.lsu_req_valid} !== {3'd0, 4'd0, 1'b0}) begin errors++; $display("FAIL mid_reset_after: got state=%0d retired=%0d lsu_valid=%b expected state=0 retired=0 lsu_valid=0", state, retired, bus.lsu_req_valid); end
  endtask

  // Scenario sequence and final report.
  initial begin
    rst = 1'b1;
    clear_inputs();
    exp_retired = 4'd0;
    test_reset();
    test_alu();
    test_load_delayed();
    test_store();
    test_branch();
    test_jump();
    test_ignore_rsp();
    test_halt();
    test_illegal();
    test_timeout();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_multicycle_ctrl.md
Name: npc_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the NPC core. It replaces single-cycle execution with an FSM that runs each instruction through fetch, execute, memory and writeback.
- Drives valid/ready handshakes to the instruction-fetch unit (IFU) and the load/store unit (LSU), plus strobes for the IR, PC and register file.
- Consumes the opcode from the latched IR and the ALU zero flag. Also counts retired instructions and detects memory-response timeouts.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 255, maximum cycles spent in any request/wait state before entering ERR. Internal counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode of the latched IR; stable from EX until next IF_REQ
- zero  in  1  ALU zero flag (branch taken when 1)
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  IFU accepts request
- ifu_rsp_valid  in  1  instruction word available
- lsu_req_valid  out  1  data-memory request
- lsu_req_ready  in  1  LSU accepts request
- lsu_rsp_valid  in  1  load data ready / store complete
- lsu_we  out  1  1 = store, 0 = load
- ir_we  out  1  latch instruction into IR
- pc_we  out  1  update PC
- pc_sel  out  1  0 = pc+4, 1 = ALU/branch target
- rf_we  out  1  register-file write strobe
- state  out  3  current FSM state (debug)
- retired  out  CNT_W  retired-instruction count
- trap  out  1  ecall/ebreak halt reached
- err  out  1  illegal opcode or timeout

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IF_REQ, retired=0, timeout counter=0. While rst=1 every strobe/valid output is forced 0; trap=0, err=0.
- State encoding: IF_REQ=0, IF_WAIT=1, EX=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=6, ERR=7.
- IF_REQ:
  - ifu_req_valid=1, held until ifu_req_ready. It must not drop or change before acceptance.
  - On valid&ready -> IF_WAIT.
- IF_WAIT: when ifu_rsp_valid=1, ir_we=1 in that same cycle (Mealy pulse) -> EX.
- EX (one cycle) decodes op:
  - 3 (load) or 35 (store) -> MEM_REQ.
  - 51, 19, 23, 111 or 103 -> WB.
  - 99 (branch): pc_we=1, pc_sel=zero, retired+1 -> IF_REQ.
  - 115 (system) -> HALT; not counted as retired.
  - Any other op -> ERR.
- MEM_REQ:
  - lsu_req_valid=1, lsu_we=(op==35), both held until lsu_req_ready.
  - On handshake -> MEM_WAIT.
- MEM_WAIT: on lsu_rsp_valid:
  - Store: pc_we=1, pc_sel=0, retired+1 -> IF_REQ.
  - Load -> WB.
- WB (one cycle):
  - rf_we=1, pc_we=1.
  - pc_sel=1 iff op is 111 or 103, else 0.
  - retired+1 -> IF_REQ.
- HALT and ERR are absorbing until rst. trap=1 in HALT and err=1 in ERR (registered via state). No valid or strobe is asserted in either state.
- Timeout:
  - Counter clears on every state transition.
  - Increments each cycle spent in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT without the exit handshake.
  - When the counter equals TIMEOUT and no handshake occurs that cycle -> ERR.
  - A handshake arriving in the TIMEOUT cycle wins (normal transition).
- Single-cycle latencies (ready=1, rsp one cycle after accept):
  - ALU/jump: 4 cycles.
  - Load: 6 cycles.
  - Store: 5 cycles.
  - Branch: 3 cycles.
- retired wraps modulo 2^CNT_W with no saturation. At most one increment per cycle.
- Reset mid-transaction: abandons any outstanding request; no retire and no pc_we on the reset edge. The IFU/LSU must discard a pending response after rst.
- ifu_rsp_valid or lsu_rsp_valid asserted in any state other than its wait state is ignored.

Test Plan:
- Reset, then op=51 with ifu ready=1 and rsp one cycle later -> state sequence 0,1,2,5,0. ir_we pulses in cycle 2. rf_we=1 and pc_we=1, pc_sel=0 in cycle 4. retired=1.
- op=3 with lsu_req_ready delayed 3 cycles -> lsu_req_valid held for 4 cycles, lsu_we=0, then MEM_WAIT, WB, rf_we=1. retired increments once; total 9 cycles.
- op=99: zero=1 -> pc_we=1, pc_sel=1 in EX. zero=0 -> pc_sel=0. rf_we stays 0 in both cases.
- op=115 -> state=6, trap=1 from next cycle onward. No further ifu_req_valid despite ready=1; retired unchanged. rst clears trap.
- TIMEOUT=4, ifu_req_ready held 0 -> err=1 and state=7 after the 5th IF_REQ cycle. Repeat with ready rising in the 5th cycle -> IF_WAIT, no error.
- CNT_W=4, retire 17 op=19 instructions -> retired=1 (wrapped). Also assert rst while in MEM_WAIT -> next state=0, retired=0, lsu_req_valid=0.
